// File: rtl/sram_arbiter_pkg.sv
// Shared types for the external SRAM arbiter: FSM states, grant encoding and
// the access-cycle counter width helper.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_VID = 1'b1
    } gnt_e;

    // Counter must reach WAIT_CYCLES, the index of the last ACCESS cycle.
    function automatic int cnt_width(input int wait_cycles);
        return $clog2(wait_cycles + 2);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the CPU request port, the video read port and the SRAM pad signals.
// Handshake: a requester raises req with stable fields and keeps both until it
// sees its one-cycle ack; fields are sampled only when the arbiter is idle.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [1:0]        cpu_be;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ub_n;
    logic              sram_lb_n;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_ack, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_ack, vid_rdata,
        output sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_dq_in,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_ack, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_ack, vid_rdata,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        output sram_dq_in,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the CPU, bit 1 is video.
// Remembers who was served last and favours the other one on contention.
module sram_rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    gnt_e last_q;
    gnt_e last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == GNT_VID) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
        if (en_i && (req_i != 2'b00)) begin
            last_d = gnt_o[1] ? GNT_VID : GNT_CPU;
        end
    end

    // "Video served last" out of reset makes the CPU win the first contention.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= GNT_VID;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Sequences asynchronous SRAM accesses for the CPU and video requesters:
// setup cycle, WAIT_CYCLES strobe cycles, then a hold cycle carrying the ack.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    sram_arbiter_if.slave  bus,
    output state_e         dbg_state_o
);

    localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    gnt_e              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dq_out_q;
    logic              dq_oe_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic              ub_n_q;
    logic              lb_n_q;
    logic              cpu_ack_q;
    logic              vid_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;
    logic [1:0]        gnt;

    sram_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   ({bus.vid_req, bus.cpu_req}),
        .en_i    (state_q == IDLE),
        .gnt_o   (gnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= GNT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            vid_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        if (gnt[0]) begin
                            gnt_q   <= GNT_CPU;
                            we_q    <= bus.cpu_we;
                            addr_q  <= bus.cpu_addr;
                            if (bus.cpu_we) begin
                                dq_out_q <= bus.cpu_wdata;
                            end
                            dq_oe_q <= bus.cpu_we;
                            oe_n_q  <= bus.cpu_we;
                            ub_n_q  <= ~bus.cpu_be[1];
                            lb_n_q  <= ~bus.cpu_be[0];
                        end else begin
                            gnt_q   <= GNT_VID;
                            we_q    <= 1'b0;
                            addr_q  <= bus.vid_addr;
                            dq_oe_q <= 1'b0;
                            oe_n_q  <= 1'b0;
                            ub_n_q  <= 1'b0;
                            lb_n_q  <= 1'b0;
                        end
                        ce_n_q  <= 1'b0;
                        we_n_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!we_q) begin
                            if (gnt_q == GNT_CPU) begin
                                cpu_rdata_q <= bus.sram_dq_in;
                            end else begin
                                vid_rdata_q <= bus.sram_dq_in;
                            end
                        end
                        // Address and write data stay put through DONE for hold time.
                        ce_n_q    <= 1'b1;
                        oe_n_q    <= 1'b1;
                        we_n_q    <= 1'b1;
                        ub_n_q    <= 1'b1;
                        lb_n_q    <= 1'b1;
                        dq_oe_q   <= 1'b0;
                        cpu_ack_q <= (gnt_q == GNT_CPU);
                        vid_ack_q <= (gnt_q == GNT_VID);
                        state_q   <= DONE;
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        we_n_q <= ~we_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.vid_ack     = vid_ack_q;
    assign bus.vid_rdata   = vid_rdata_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_ub_n   = ub_n_q;
    assign bus.sram_lb_n   = lb_n_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small byte-lane SRAM model on the pads.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    state_e dbg_state;
    int     checks = 0;
    int     failures = 0;
    logic [DW-1:0] mem [256];

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (sif.slave),
        .dbg_state_o (dbg_state)
    );

    // SRAM model: byte-lane writes while we_n is low, reads while oe_n is low.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h10] <= 16'h1234;
        end else if (!sif.sram_ce_n && !sif.sram_we_n) begin
            if (!sif.sram_ub_n) mem[sif.sram_addr[7:0]][15:8] <= sif.sram_dq_out[15:8];
            if (!sif.sram_lb_n) mem[sif.sram_addr[7:0]][7:0]  <= sif.sram_dq_out[7:0];
        end
    end

    assign sif.sram_dq_in = (!sif.sram_ce_n && !sif.sram_oe_n) ? mem[sif.sram_addr[7:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ce_n"},  32'(sif.sram_ce_n), 32'd1);
        check({tag, "_oe_n"},  32'(sif.sram_oe_n), 32'd1);
        check({tag, "_we_n"},  32'(sif.sram_we_n), 32'd1);
        check({tag, "_ub_n"},  32'(sif.sram_ub_n), 32'd1);
        check({tag, "_lb_n"},  32'(sif.sram_lb_n), 32'd1);
        check({tag, "_dq_oe"}, 32'(sif.sram_dq_oe), 32'd0);
        check({tag, "_cack"},  32'(sif.cpu_ack), 32'd0);
        check({tag, "_vack"},  32'(sif.vid_ack), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // One access from idle; strobes are tallied per cycle until the ack.
    task automatic do_access(input string tag, input bit who, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [1:0] be, input logic [DW-1:0] exp_rd);
        int k = 0;
        int ack_k = 0;
        int ce_cnt = 0;
        int we_cnt = 0;
        int we_first = 0;
        int oe_cnt = 0;
        int dqoe_cnt = 0;
        int dq_bad = 0;
        int addr_bad = 0;
        int other_ack = 0;
        logic ub_seen = 1'b1;
        logic lb_seen = 1'b1;
        logic done_ce = 1'b0;
        logic [AW-1:0] done_addr = '0;
        logic [DW-1:0] rd = '0;
        logic exp_ub = who ? 1'b0 : ~be[1];
        logic exp_lb = who ? 1'b0 : ~be[0];
        if (!who) begin
            sif.cpu_req = 1'b1; sif.cpu_we = we; sif.cpu_addr = addr;
            sif.cpu_wdata = wdata; sif.cpu_be = be;
        end else begin
            sif.vid_req = 1'b1; sif.vid_addr = addr;
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            k++;
            if (!sif.sram_ce_n) begin
                ce_cnt++;
                ub_seen = sif.sram_ub_n;
                lb_seen = sif.sram_lb_n;
                if (sif.sram_addr != addr) addr_bad++;
            end
            if (!sif.sram_we_n) begin
                we_cnt++;
                if (we_first == 0) we_first = k;
            end
            if (!sif.sram_oe_n) oe_cnt++;
            if (sif.sram_dq_oe) begin
                dqoe_cnt++;
                if (sif.sram_dq_out != wdata) dq_bad++;
            end
            if (who ? sif.cpu_ack : sif.vid_ack) other_ack++;
            if (who ? sif.vid_ack : sif.cpu_ack) begin
                ack_k = k;
                rd = who ? sif.vid_rdata : sif.cpu_rdata;
                done_ce = sif.sram_ce_n;
                done_addr = sif.sram_addr;
                break;
            end
        end
        sif.cpu_req = 1'b0;
        sif.vid_req = 1'b0;
        check({tag, "_ack_latency"}, ack_k, 3);
        check({tag, "_ce_cycles"}, ce_cnt, 2);
        check({tag, "_we_cycles"}, we_cnt, we ? 1 : 0);
        check({tag, "_we_first"}, we_first, we ? 2 : 0);
        check({tag, "_oe_cycles"}, oe_cnt, we ? 0 : 2);
        check({tag, "_dqoe_cycles"}, dqoe_cnt, we ? 2 : 0);
        check({tag, "_dq_out_bad"}, dq_bad, 0);
        check({tag, "_addr_bad"}, addr_bad, 0);
        check({tag, "_ub_n"}, 32'(ub_seen), 32'(exp_ub));
        check({tag, "_lb_n"}, 32'(lb_seen), 32'(exp_lb));
        check({tag, "_other_ack"}, other_ack, 0);
        check({tag, "_done_ce_n"}, 32'(done_ce), 32'd1);
        check({tag, "_done_addr"}, 32'(done_addr), 32'(addr));
        if (!we) check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        tick();
        check({tag, "_ack_drop"}, 32'(who ? sif.vid_ack : sif.cpu_ack), 32'd0);
        check({tag, "_back_idle"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] got;
        int         ack_cnt;
        sif.cpu_req = 1'b0; sif.cpu_we = 1'b0; sif.cpu_addr = '0;
        sif.cpu_wdata = '0; sif.cpu_be = 2'b00;
        sif.vid_req = 1'b0; sif.vid_addr = '0;

        // Reset held for three cycles.
        reset_n = 1'b0;
        repeat (3) tick();
        check_idle_outputs("rst");
        check("rst_addr",  32'(sif.sram_addr), 32'h0);
        check("rst_dqout", 32'(sif.sram_dq_out), 32'h0);
        check("rst_crd",   32'(sif.cpu_rdata), 32'h0);
        check("rst_vrd",   32'(sif.vid_rdata), 32'h0);
        reset_n = 1'b1;
        tick();
        check_idle_outputs("post_rst");

        do_access("cpu_wr",   1'b0, 1'b1, 20'h00ABC, 16'hBEEF, 2'b11, 16'h0000);
        do_access("vid_rd",   1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'h1234);
        check("cpu_rdata_held", 32'(sif.cpu_rdata), 32'h0);
        do_access("cpu_rd_wr_back", 1'b0, 1'b0, 20'h00ABC, 16'h0000, 2'b11, 16'hBEEF);
        do_access("cpu_ub_wr", 1'b0, 1'b1, 20'h00020, 16'hA5C3, 2'b10, 16'h0000);
        do_access("cpu_ub_rd", 1'b0, 1'b0, 20'h00020, 16'h0000, 2'b11, 16'hA500);
        do_access("cpu_be0_wr", 1'b0, 1'b1, 20'h00020, 16'h5A5A, 2'b00, 16'h0000);
        do_access("cpu_be0_rd", 1'b0, 1'b0, 20'h00020, 16'h0000, 2'b11, 16'hA500);
        check("vid_rdata_held", 32'(sif.vid_rdata), 32'h1234);

        // Contention straight after reset: CPU first, then alternate every 4 cycles.
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        exp_q.push_back({7'd3, 1'b0});
        exp_q.push_back({7'd7, 1'b1});
        exp_q.push_back({7'd11, 1'b0});
        exp_q.push_back({7'd15, 1'b1});
        sif.cpu_req = 1'b1; sif.cpu_we = 1'b0; sif.cpu_addr = 20'h00010; sif.cpu_be = 2'b11;
        sif.vid_req = 1'b1; sif.vid_addr = 20'h00010;
        ack_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (sif.cpu_ack && sif.vid_ack) check("cont_dual_ack", 32'd1, 32'd0);
            if (sif.cpu_ack || sif.vid_ack) begin
                ack_cnt++;
                got = {k[6:0], sif.vid_ack};
                if (exp_q.size() > 0) check("cont_order", 32'(got), 32'(exp_q.pop_front()));
                else check("cont_extra_ack", 32'(got), 32'hFF);
            end
        end
        sif.cpu_req = 1'b0;
        sif.vid_req = 1'b0;
        check("cont_ack_count", ack_cnt, 4);
        check("cont_cpu_rdata", 32'(sif.cpu_rdata), 32'h1234);
        tick();
        check("cont_idle", 32'(dbg_state), 32'(IDLE));

        // Reset during the second ACCESS cycle of a read: no ack, then re-issue.
        sif.cpu_req = 1'b1; sif.cpu_we = 1'b0; sif.cpu_addr = 20'h00010; sif.cpu_be = 2'b11;
        tick();
        check("mid_access1", 32'(dbg_state), 32'(ACCESS));
        tick();
        check("mid_access2_oe_n", 32'(sif.sram_oe_n), 32'd0);
        reset_n = 1'b0;
        tick();
        check_idle_outputs("mid_rst");
        check("mid_rst_crd", 32'(sif.cpu_rdata), 32'h0);
        reset_n = 1'b1;
        sif.cpu_req = 1'b0;
        ack_cnt = 0;
        repeat (8) begin
            tick();
            if (sif.cpu_ack) ack_cnt++;
        end
        check("mid_rst_no_ack", ack_cnt, 0);
        do_access("reissue_rd", 1'b0, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
